// File: rtl/fifo_drain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_ctrl_if
// Description : FIFO-side flags/data and downstream valid/ready bundle for
//               the FIFO drain controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_drain_ctrl_if #(
    parameter int DATA_SIZE       = 6,
    parameter int MAIN_QUEUE_SIZE = 4,
    parameter int CNT_SIZE        = 8
);
    logic                       enable;
    logic                       fifo_empty;
    logic                       almost_empty;
    logic [MAIN_QUEUE_SIZE-1:0] data_count;
    logic [DATA_SIZE-1:0]       buff_out;
    logic [MAIN_QUEUE_SIZE-1:0] umb_burst;
    logic                       flush_req;
    logic                       ready_in;
    logic                       read;
    logic [DATA_SIZE-1:0]       data_out;
    logic                       valid_out;
    logic                       draining;
    logic [CNT_SIZE-1:0]        pop_count;

    modport master (
        input  enable, fifo_empty, almost_empty, data_count, buff_out,
               umb_burst, flush_req, ready_in,
        output read, data_out, valid_out, draining, pop_count
    );

    modport slave (
        output enable, fifo_empty, almost_empty, data_count, buff_out,
               umb_burst, flush_req, ready_in,
        input  read, data_out, valid_out, draining, pop_count
    );
endinterface
`default_nettype wire

// File: rtl/fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_ctrl
// Description : FIFO read-side controller: pop decision, 2-entry skid buffer
//               absorbing read latency, valid/ready output. Optional delivered
//               word counter enabled by macro DRAIN_POP_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_ctrl #(
    parameter int DATA_SIZE       = 6,
    parameter int MAIN_QUEUE_SIZE = 4,
    parameter int CNT_SIZE        = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fifo_drain_ctrl_if.master bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_read_q;
    logic [1:0]           r_count;
    logic [DATA_SIZE-1:0] r_skid0;
    logic [DATA_SIZE-1:0] r_skid1;
    logic [1:0]           w_slots;
    logic                 w_pop;
    logic                 w_read;
    logic                 w_start;
    logic                 w_unused_almost_empty;

    assign w_unused_almost_empty = bus.almost_empty;

    assign w_pop   = (r_count != 2'd0) && bus.ready_in;
    assign w_slots = r_count + {1'b0, r_read_q};
    // A zero threshold means "any occupancy", so test the empty flag instead.
    assign w_start = bus.flush_req ||
                     ((bus.umb_burst == '0) ? !bus.fifo_empty
                                            : (bus.data_count >= bus.umb_burst));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_read      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.fifo_empty && !r_read_q) begin
                    w_state_nxt = S_IDLE;
                end
                // A full skid may still take a word if the head leaves this cycle.
                w_read = bus.enable && !bus.fifo_empty && !reset &&
                         ((w_slots < 2'd2) || ((w_slots == 2'd2) && w_pop));
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_q <= 1'b0;
            r_count  <= 2'd0;
            r_skid0  <= '0;
            r_skid1  <= '0;
        end else begin
            r_read_q <= w_read;
            if (r_read_q && w_pop) begin
                if (r_count == 2'd1) begin
                    r_skid0 <= bus.buff_out;
                end else begin
                    r_skid0 <= r_skid1;
                    r_skid1 <= bus.buff_out;
                end
            end else if (r_read_q) begin
                if (r_count == 2'd0) begin
                    r_skid0 <= bus.buff_out;
                end else begin
                    r_skid1 <= bus.buff_out;
                end
                r_count <= r_count + 2'd1;
            end else if (w_pop) begin
                r_skid0 <= r_skid1;
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign bus.read      = w_read;
    assign bus.data_out  = r_skid0;
    assign bus.valid_out = (r_count != 2'd0);
    assign bus.draining  = (r_state == S_DRAIN);

`ifdef DRAIN_POP_COUNT_EN
    logic [CNT_SIZE-1:0] r_pop_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pop_count <= '0;
        end else if (w_pop && (r_pop_count != '1)) begin
            r_pop_count <= r_pop_count + CNT_SIZE'(1);
        end
    end

    assign bus.pop_count = r_pop_count;
`else
    assign bus.pop_count = '0;
`endif

endmodule
`default_nettype wire
